// File: rtl/countdown_timer_bcd_if.sv
// Control and status bundle between the key/switch logic (master) and the
// countdown timer (slave).
interface countdown_timer_bcd_if #(
  parameter int VAL_W  = 10,
  parameter int DIGITS = 3
);
  logic                  Load;
  logic [VAL_W-1:0]      LoadValue;
  logic                  Start;
  logic                  Pause;
  logic                  AutoReload;
  logic [VAL_W-1:0]      Count;
  logic [4*DIGITS-1:0]   Bcd;
  logic                  BcdValid;
  logic                  Overrange;
  logic                  Running;
  logic                  Done;
  logic                  DonePulse;

  modport master (
    output Load, LoadValue, Start, Pause, AutoReload,
    input  Count, Bcd, BcdValid, Overrange, Running, Done, DonePulse
  );

  modport slave (
    input  Load, LoadValue, Start, Pause, AutoReload,
    output Count, Bcd, BcdValid, Overrange, Running, Done, DonePulse
  );
endinterface

// File: rtl/countdown_timer_bcd.sv
// Countdown timer with rate divider, pause/auto-reload control and a
// sequential double-dabble converter feeding the 7-segment digit decoders.
module countdown_timer_bcd #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int VAL_W       = 10,
  parameter int DIGITS      = 3,
  parameter int DEFAULT_VAL = 120
) (
  input logic Clock,
  input logic Reset,
  countdown_timer_bcd_if.slave bus
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(VAL_W);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [VAL_W-1:0] DEFAULT_Q = VAL_W'(DEFAULT_VAL);
  localparam logic [VAL_W-1:0] ONE_Q     = VAL_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t           state_q, state_d;
  logic [VAL_W-1:0] count_q, reload_q;
  logic [DIV_W-1:0] div_q;
  logic             done_pulse_q;
  logic             run_active, tick, start_go, reload_go, expire;

  // Load beats everything; Pause beats Start while running.
  always_comb begin
    run_active = (state_q == RUN) && !bus.Load && !bus.Pause;
    tick       = run_active && (div_q == '0);
    start_go   = (state_q == IDLE) && !bus.Load && bus.Start && (count_q != '0);
    reload_go  = tick && (count_q == ONE_Q) && bus.AutoReload && (reload_q != '0);
    expire     = tick && (count_q <= ONE_Q) && !reload_go;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.Load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_go) state_d = RUN;
        RUN:     if (bus.Pause) state_d = PAUSED;
                 else if (expire) state_d = EXPIRED;
        PAUSED:  if (bus.Start) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bus.Running = (state_q == RUN);
    bus.Done    = (state_q == EXPIRED);
  end

  // A resumed run keeps the divider phase it had when paused.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q      <= DEFAULT_Q;
      reload_q     <= DEFAULT_Q;
      div_q        <= DIV_LAST;
      done_pulse_q <= 1'b0;
    end else if (bus.Load) begin
      count_q      <= bus.LoadValue;
      reload_q     <= bus.LoadValue;
      div_q        <= DIV_LAST;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= tick && (count_q == ONE_Q);
      if (start_go)
        div_q <= DIV_LAST;
      else if (run_active)
        div_q <= (div_q == '0) ? DIV_LAST : div_q - 1'b1;
      if (tick) begin
        if (count_q > ONE_Q)  count_q <= count_q - 1'b1;
        else if (reload_go)   count_q <= reload_q;
        else                  count_q <= '0;
      end
    end
  end

  assign bus.Count     = count_q;
  assign bus.DonePulse = done_pulse_q;

  logic                 bcd_busy, shadow_valid, ovr_pending, ovr_q, bcd_valid_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [VAL_W-1:0]     bin_sr, shadow;
  logic [BCD_W-1:0]     bcd_sr, bcd_adj, bcd_step, bcd_q;
  logic [VAL_W-1:0]     bin_step;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < DIGITS; d++)
      if (bcd_adj[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_adj[4*d +: 4] + 4'd3;
    bcd_step = {bcd_adj[BCD_W-2:0], bin_sr[VAL_W-1]};
    bin_step = {bin_sr[VAL_W-2:0], 1'b0};
  end

  // A bit shifted out of the top digit means the value has no room in DIGITS
  // digits; the remaining digits are then the low-order part of the value.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bcd_busy     <= 1'b0;
      shadow_valid <= 1'b0;
      shadow       <= '0;
      bin_sr       <= '0;
      bcd_sr       <= '0;
      bit_cnt      <= '0;
      ovr_pending  <= 1'b0;
      ovr_q        <= 1'b0;
      bcd_q        <= '0;
      bcd_valid_q  <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      if (!bcd_busy) begin
        if (!shadow_valid || (count_q != shadow)) begin
          bcd_busy     <= 1'b1;
          shadow_valid <= 1'b1;
          shadow       <= count_q;
          bin_sr       <= count_q;
          bcd_sr       <= '0;
          bit_cnt      <= CNT_W'(VAL_W - 1);
          ovr_pending  <= 1'b0;
        end
      end else begin
        bin_sr      <= bin_step;
        bcd_sr      <= bcd_step;
        ovr_pending <= ovr_pending | bcd_adj[BCD_W-1];
        if (bit_cnt == '0) begin
          bcd_busy    <= 1'b0;
          bcd_q       <= bcd_step;
          ovr_q       <= ovr_pending | bcd_adj[BCD_W-1];
          bcd_valid_q <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.Bcd       = bcd_q;
  assign bus.Overrange = ovr_q;
  assign bus.BcdValid  = bcd_valid_q;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench: directed control sequences queue expected BCD results and
// expiry pulses; a monitor pops and compares whenever the timer presents them.
module tb_countdown_timer_bcd;
  logic Clock;
  logic Reset;

  countdown_timer_bcd_if #(.VAL_W(8), .DIGITS(3)) bus ();

  countdown_timer_bcd #(
    .CLK_HZ(10), .TICK_HZ(1), .VAL_W(8), .DIGITS(3), .DEFAULT_VAL(120)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int bcd_valid_seen = 0;
  int done_pulse_seen = 0;
  logic [12:0] expect_bcd[$];
  logic [7:0]  expect_done[$];
  int          pulse_cycles[$];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  // Holds the given controls for exactly one rising edge.
  task automatic applyStimulus(input logic load, input logic [7:0] value,
                               input logic start, input logic pause);
    bus.Load      = load;
    bus.LoadValue = value;
    bus.Start     = start;
    bus.Pause     = pause;
    wait_cycles(1);
    bus.Load  = 1'b0;
    bus.Start = 1'b0;
    bus.Pause = 1'b0;
  endtask

  function automatic logic [12:0] exp_bcd(input int v);
    logic [12:0] r;
    r        = '0;
    r[11:8]  = 4'(v / 100 % 10);
    r[7:4]   = 4'(v / 10 % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  always @(negedge Clock) begin
    logic [12:0] eb;
    logic [7:0]  ed;
    cycle++;
    if (!Reset) begin
      if (bus.BcdValid) begin
        bcd_valid_seen++;
        checkOutput("bcd_pending", int'(expect_bcd.size() != 0), 1);
        if (expect_bcd.size() != 0) begin
          eb = expect_bcd.pop_front();
          checkOutput("bcd_value", int'({bus.Overrange, bus.Bcd}), int'(eb));
        end
      end
      if (bus.DonePulse) begin
        done_pulse_seen++;
        pulse_cycles.push_back(cycle);
        checkOutput("done_pending", int'(expect_done.size() != 0), 1);
        if (expect_done.size() != 0) begin
          ed = expect_done.pop_front();
          checkOutput("done_count", int'(bus.Count), int'(ed));
        end
      end
    end
  end

  initial begin
    logic [7:0] ar_seq[6];
    ar_seq = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
    Reset = 1'b1;
    bus.Load = 1'b0; bus.LoadValue = '0; bus.Start = 1'b0;
    bus.Pause = 1'b0; bus.AutoReload = 1'b0;
    expect_bcd.push_back(13'h120);
    @(negedge Clock); #1;
    checkOutput("rst_count", int'(bus.Count), 120);
    checkOutput("rst_bcd", int'(bus.Bcd), 0);
    checkOutput("rst_bcdvalid", int'(bus.BcdValid), 0);
    checkOutput("rst_overrange", int'(bus.Overrange), 0);
    checkOutput("rst_running", int'(bus.Running), 0);
    checkOutput("rst_done", int'(bus.Done), 0);
    checkOutput("rst_donepulse", int'(bus.DonePulse), 0);
    Reset = 1'b0;
    wait_cycles(10);
    checkOutput("t1_bcd_default", int'(bus.Bcd), 12'h120);
    checkOutput("t1_bcdvalid_once", bcd_valid_seen, 1);

    // Full countdown from the default value to expiry.
    for (int v = 119; v >= 0; v--) expect_bcd.push_back(exp_bcd(v));
    expect_done.push_back(8'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cycles(1190);
    checkOutput("t1_count_last", int'(bus.Count), 1);
    checkOutput("t1_running", int'(bus.Running), 1);
    wait_cycles(10);
    checkOutput("t1_count_zero", int'(bus.Count), 0);
    checkOutput("t1_done", int'(bus.Done), 1);
    checkOutput("t1_running_off", int'(bus.Running), 0);
    checkOutput("t1_donepulse", int'(bus.DonePulse), 1);
    wait_cycles(10);
    checkOutput("t1_bcd_zero", int'(bus.Bcd), 12'h000);
    checkOutput("t1_pulses", done_pulse_seen, 1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("t1_expired_start_done", int'(bus.Done), 1);
    checkOutput("t1_expired_start_count", int'(bus.Count), 0);

    // Pause holds both the count and the divider phase.
    expect_bcd.push_back(13'h120);
    applyStimulus(1'b1, 8'd120, 1'b0, 1'b0);
    checkOutput("t2_load_count", int'(bus.Count), 120);
    checkOutput("t2_load_done", int'(bus.Done), 0);
    wait_cycles(10);
    expect_bcd.push_back(13'h119);
    expect_bcd.push_back(13'h118);
    expect_bcd.push_back(13'h117);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cycles(35);
    checkOutput("t2_count_35", int'(bus.Count), 117);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    wait_cycles(50);
    checkOutput("t2_paused_count", int'(bus.Count), 117);
    checkOutput("t2_paused_running", int'(bus.Running), 0);
    expect_bcd.push_back(13'h116);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("t2_resumed", int'(bus.Running), 1);
    wait_cycles(4);
    checkOutput("t2_no_early_tick", int'(bus.Count), 117);
    wait_cycles(1);
    checkOutput("t2_tick_after_5", int'(bus.Count), 116);

    // Load during a run returns to IDLE and converts in VAL_W+1 cycles.
    wait_cycles(9);
    expect_bcd.push_back(13'h045);
    applyStimulus(1'b1, 8'd45, 1'b0, 1'b0);
    checkOutput("t3_count", int'(bus.Count), 45);
    checkOutput("t3_running", int'(bus.Running), 0);
    wait_cycles(8);
    checkOutput("t3_not_yet_valid", int'(bus.BcdValid), 0);
    wait_cycles(1);
    checkOutput("t3_valid_at_9", int'(bus.BcdValid), 1);
    checkOutput("t3_bcd", int'(bus.Bcd), 12'h045);
    expect_bcd.push_back(13'h044);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cycles(10);
    checkOutput("t3_resume_count", int'(bus.Count), 44);
    checkOutput("t3_resume_running", int'(bus.Running), 1);
    wait_cycles(9);

    // Auto-reload cycles 3,2,1 and pulses on each expiry without stopping.
    bus.AutoReload = 1'b1;
    expect_bcd.push_back(13'h003);
    applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
    checkOutput("t4_load_count", int'(bus.Count), 3);
    wait_cycles(10);
    foreach (ar_seq[i]) expect_bcd.push_back(exp_bcd(int'(ar_seq[i])));
    expect_done.push_back(8'd3);
    expect_done.push_back(8'd3);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    foreach (ar_seq[i]) begin
      wait_cycles(10);
      checkOutput($sformatf("t4_count_%0d", i), int'(bus.Count), int'(ar_seq[i]));
      checkOutput($sformatf("t4_done_%0d", i), int'(bus.Done), 0);
      checkOutput($sformatf("t4_running_%0d", i), int'(bus.Running), 1);
    end
    checkOutput("t4_pulses", done_pulse_seen, 3);
    if (pulse_cycles.size() == 3)
      checkOutput("t4_pulse_spacing", pulse_cycles[2] - pulse_cycles[1], 30);

    // Asynchronous reset between edges, mid-run and mid-conversion.
    wait_cycles(3);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("t5_count", int'(bus.Count), 120);
    checkOutput("t5_running", int'(bus.Running), 0);
    checkOutput("t5_done", int'(bus.Done), 0);
    checkOutput("t5_bcd", int'(bus.Bcd), 0);
    checkOutput("t5_bcdvalid", int'(bus.BcdValid), 0);
    checkOutput("t5_donepulse", int'(bus.DonePulse), 0);
    checkOutput("t5_overrange", int'(bus.Overrange), 0);
    expect_bcd.delete();
    expect_bcd.push_back(13'h120);
    @(negedge Clock); #1;
    Reset = 1'b0;
    bus.AutoReload = 1'b0;
    wait_cycles(10);
    checkOutput("t5_bcd_after", int'(bus.Bcd), 12'h120);
    checkOutput("t5_idle", int'(bus.Running), 0);

    // Load wins over Start; Start with a zero count stays idle.
    expect_bcd.push_back(13'h050);
    applyStimulus(1'b1, 8'd50, 1'b1, 1'b0);
    checkOutput("t6_count", int'(bus.Count), 50);
    checkOutput("t6_running", int'(bus.Running), 0);
    wait_cycles(10);
    expect_bcd.push_back(13'h000);
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    wait_cycles(10);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    wait_cycles(12);
    checkOutput("t6_zero_running", int'(bus.Running), 0);
    checkOutput("t6_zero_done", int'(bus.Done), 0);
    checkOutput("t6_zero_count", int'(bus.Count), 0);
    checkOutput("t6_pulses", done_pulse_seen, 3);

    checkOutput("bcd_queue_drained", expect_bcd.size(), 0);
    checkOutput("done_queue_drained", expect_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
